hist_eq_divider: RTL and testbench

- Histogram-equalization scaling stage.
- Reads 256 CDF bins (four 32-bit bins per 128-bit word) from the shared scratch memory and computes eq(v) = floor((cdf(v) - cdf_min) * 255 / (NUM_PIXELS - cdf_min)) for each bin.
- Writes the 256 equalized values back to scratch memory as a lookup table.
- Sits between the CDF accumulator and the pixel remapper; talks to a 2-read/1-write 128-bit scratch memory.

---
 rtl/hist_eq_divider.sv | 214 +++++++++++++++++++++
 tb/tb_hist_eq_divider.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hist_eq_divider.sv
// Purpose: histogram-equalization scaling; turns 256 CDF bins in scratch memory into a 256-entry LUT.
// Latency: 13 cycles per word pair (read, capture, prep, 8 divide steps, 2 writes); 416 cycles for 32 pairs.
// Backpressure: none; the memory is always ready and the engine runs to completion once started.
//
// Ports:
//   clk, reset (async, active-low)   - clock and reset
//   enable, cdf_min                  - start request (rising edge in IDLE) and CDF floor, latched at start
//   div_sc_mem_rd_addr1/2, _rd_data1/2 - even/odd word reads, data one cycle after address
//   div_sc_mem_wt_addr/_wt_data/_wt_en - result writes, four zero-extended 8-bit results per word
//   div_sc_mem_rd_done               - pulse while the last read pair is captured
//   div_sc_mem_wt_done               - high after the final write until the next start or reset
// Build option: define HIST_EQ_ROUND_NEAREST_EN to round results to nearest instead of floor.
module hist_eq_divider #(
    parameter logic [15:0] CDF_BASE_ADDR = 16'd0,
    parameter logic [15:0] OUT_BASE_ADDR = 16'd64,
    parameter int          NUM_WORDS     = 64,
    parameter logic [31:0] NUM_PIXELS    = 32'd16384
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [31:0]  cdf_min,
    input  logic [127:0] div_sc_mem_rd_data1,
    input  logic [127:0] div_sc_mem_rd_data2,
    output logic [127:0] div_sc_mem_wt_data,
    output logic [15:0]  div_sc_mem_rd_addr1,
    output logic [15:0]  div_sc_mem_rd_addr2,
    output logic [15:0]  div_sc_mem_wt_addr,
    output logic         div_sc_mem_wt_en,
    output logic         div_sc_mem_rd_done,
    output logic         div_sc_mem_wt_done
);

    localparam int NUM_PAIRS = NUM_WORDS / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_PREP,
        S_DIV,
        S_WRITE0,
        S_WRITE1,
        S_DONE
    } state_t;

    state_t       state, state_nxt;
    logic         en_q;
    logic         start;
    logic         last_pair;
    logic [14:0]  pair_idx;
    logic [2:0]   iter;
    logic [31:0]  cmin_q;
    logic [31:0]  div_q;
    logic         degen_q;
    logic [39:0]  dvs_q;

    logic [31:0]  cdf_q    [8];
    logic [40:0]  rem_q    [8];
    logic [7:0]   quo_q    [8];
    logic         zero_q   [8];
    logic         sat_q    [8];

    logic [40:0]  rem_nxt  [8];
    logic [7:0]   quo_nxt  [8];
    logic [40:0]  rem_init [8];
    logic [7:0]   res_fin  [8];
    logic [7:0]   res_last [8];

    assign start     = (state == S_IDLE) && enable && !en_q;
    assign last_pair = (pair_idx == 15'(NUM_PAIRS - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_READ;
            S_READ:    state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_PREP;
            S_PREP:    state_nxt = S_DIV;
            S_DIV:     if (iter == 3'd7) state_nxt = S_WRITE0;
            S_WRITE0:  state_nxt = S_WRITE1;
            S_WRITE1:  state_nxt = last_pair ? S_DONE : S_READ;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Per-lane numerator setup and one restoring-divide step. The quotient is
    // shifted in MSB first against a divisor that starts at D<<7 and halves
    // each step; since cdf < NUM_PIXELS implies N < 256*D, 8 steps suffice.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rem_init[i] = {1'b0, {8'd0, cdf_q[i] - cmin_q} * 40'd255};
`ifdef HIST_EQ_ROUND_NEAREST_EN
            rem_init[i] = rem_init[i] + {10'd0, div_q[31:1]};
`endif
            rem_nxt[i] = rem_q[i];
            quo_nxt[i] = {quo_q[i][6:0], 1'b0};
            if (rem_q[i] >= {1'b0, dvs_q}) begin
                rem_nxt[i] = rem_q[i] - {1'b0, dvs_q};
                quo_nxt[i] = {quo_q[i][6:0], 1'b1};
            end
            // Clamp flags override whatever the divider produced.
            res_fin[i]  = zero_q[i] ? 8'd0 : (sat_q[i] ? 8'd255 : quo_q[i]);
            res_last[i] = zero_q[i] ? 8'd0 : (sat_q[i] ? 8'd255 : quo_nxt[i]);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q                <= 1'b0;
            pair_idx            <= '0;
            iter                <= '0;
            cmin_q              <= '0;
            div_q               <= '0;
            degen_q             <= 1'b0;
            dvs_q               <= '0;
            div_sc_mem_wt_data  <= '0;
            div_sc_mem_rd_addr1 <= '0;
            div_sc_mem_rd_addr2 <= '0;
            div_sc_mem_wt_addr  <= '0;
            div_sc_mem_wt_en    <= 1'b0;
            div_sc_mem_rd_done  <= 1'b0;
            div_sc_mem_wt_done  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cdf_q[i]  <= '0;
                rem_q[i]  <= '0;
                quo_q[i]  <= '0;
                zero_q[i] <= 1'b0;
                sat_q[i]  <= 1'b0;
            end
        end else begin
            en_q <= enable;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cmin_q              <= cdf_min;
                        div_q               <= NUM_PIXELS - cdf_min;
                        // Covers D == 0 and a wrapped (negative) divisor.
                        degen_q             <= (cdf_min >= NUM_PIXELS);
                        pair_idx            <= '0;
                        div_sc_mem_wt_done  <= 1'b0;
                        div_sc_mem_rd_addr1 <= CDF_BASE_ADDR;
                        div_sc_mem_rd_addr2 <= CDF_BASE_ADDR + 16'd1;
                    end
                end
                S_READ: begin
                    // Registered so the pulse lands in the CAPTURE cycle.
                    div_sc_mem_rd_done <= last_pair;
                end
                S_CAPTURE: begin
                    div_sc_mem_rd_done <= 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        cdf_q[i]     <= div_sc_mem_rd_data1[32*i +: 32];
                        cdf_q[i + 4] <= div_sc_mem_rd_data2[32*i +: 32];
                    end
                end
                S_PREP: begin
                    dvs_q <= {1'b0, div_q, 7'd0};
                    iter  <= '0;
                    for (int i = 0; i < 8; i++) begin
                        zero_q[i] <= (cdf_q[i] <= cmin_q);
                        sat_q[i]  <= (cdf_q[i] >= NUM_PIXELS) || degen_q;
                        rem_q[i]  <= rem_init[i];
                        quo_q[i]  <= '0;
                    end
                end
                S_DIV: begin
                    dvs_q <= dvs_q >> 1;
                    iter  <= iter + 3'd1;
                    for (int i = 0; i < 8; i++) begin
                        rem_q[i] <= rem_nxt[i];
                        quo_q[i] <= quo_nxt[i];
                    end
                    if (iter == 3'd7) begin
                        div_sc_mem_wt_en   <= 1'b1;
                        div_sc_mem_wt_addr <= OUT_BASE_ADDR + {pair_idx, 1'b0};
                        div_sc_mem_wt_data <= {24'd0, res_last[3], 24'd0, res_last[2],
                                               24'd0, res_last[1], 24'd0, res_last[0]};
                    end
                end
                S_WRITE0: begin
                    div_sc_mem_wt_addr <= div_sc_mem_wt_addr + 16'd1;
                    div_sc_mem_wt_data <= {24'd0, res_fin[7], 24'd0, res_fin[6],
                                           24'd0, res_fin[5], 24'd0, res_fin[4]};
                end
                S_WRITE1: begin
                    div_sc_mem_wt_en <= 1'b0;
                    if (last_pair) begin
                        div_sc_mem_wt_done <= 1'b1;
                    end else begin
                        pair_idx            <= pair_idx + 15'd1;
                        div_sc_mem_rd_addr1 <= div_sc_mem_rd_addr1 + 16'd2;
                        div_sc_mem_rd_addr2 <= div_sc_mem_rd_addr2 + 16'd2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hist_eq_divider.sv
// Bench for hist_eq_divider: CDF memory model, write scoreboard fed from a reference
// equalization function, directed runs covering reset, basic, clamp, degenerate and abort cases.
module tb_hist_eq_divider;

    localparam logic [15:0] CDF_BASE = 16'd0;
    localparam logic [15:0] OUT_BASE = 16'd64;
    localparam int          NW       = 64;
    localparam logic [31:0] NP       = 32'd16384;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [31:0]  cdf_min = '0;
    logic [127:0] rd_data1, rd_data2;
    logic [127:0] wt_data;
    logic [15:0]  rd_addr1, rd_addr2, wt_addr;
    logic         wt_en, rd_done, wt_done;

    always #5 clk = ~clk;

    hist_eq_divider #(
        .CDF_BASE_ADDR(CDF_BASE),
        .OUT_BASE_ADDR(OUT_BASE),
        .NUM_WORDS(NW),
        .NUM_PIXELS(NP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .cdf_min(cdf_min),
        .div_sc_mem_rd_data1(rd_data1),
        .div_sc_mem_rd_data2(rd_data2),
        .div_sc_mem_wt_data(wt_data),
        .div_sc_mem_rd_addr1(rd_addr1),
        .div_sc_mem_rd_addr2(rd_addr2),
        .div_sc_mem_wt_addr(wt_addr),
        .div_sc_mem_wt_en(wt_en),
        .div_sc_mem_rd_done(rd_done),
        .div_sc_mem_wt_done(wt_done)
    );

    // Scratch memory model: CDF region (words 0..63) and LUT region (words 64..127).
    logic [127:0] cdf_mem [0:63];
    logic [127:0] out_mem [0:63];

    always @(posedge clk) begin
        rd_data1 <= (rd_addr1 < 16'd64) ? cdf_mem[rd_addr1[5:0]] : '0;
        rd_data2 <= (rd_addr2 < 16'd64) ? cdf_mem[rd_addr2[5:0]] : '0;
        if (wt_en && wt_addr >= 16'd64 && wt_addr < 16'd128) out_mem[wt_addr[5:0]] <= wt_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference equalization, straight from the definition.
    function automatic logic [7:0] model_eq(input logic [31:0] c, input logic [31:0] m);
        longint unsigned d, n, q;
        if (c <= m) return 8'd0;
        if (c >= NP || m >= NP) return 8'd255;
        d = longint'(NP - m);
        n = longint'(c - m) * 255;
`ifdef HIST_EQ_ROUND_NEAREST_EN
        n = n + d / 2;
`endif
        q = n / d;
        if (q > 255) q = 255;
        return q[7:0];
    endfunction

    function automatic logic [127:0] exp_word(input logic [127:0] w, input logic [31:0] m);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) r[32*l +: 32] = {24'd0, model_eq(w[32*l +: 32], m)};
        return r;
    endfunction

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t sb[$];

    task automatic push_run(input logic [31:0] m);
        wr_t e;
        for (int w = 0; w < NW; w++) begin
            e.addr = OUT_BASE + 16'(w);
            e.data = exp_word(cdf_mem[w], m);
            sb.push_back(e);
        end
    endtask

    // Output monitor, sampled 1 time unit after the active edge.
    int n_wr      = 0;
    int n_rd_done = 0;
    int wt_run    = 0;
    int done_cyc  = 0;
    logic done_q  = 1'b0;

    always @(posedge clk) begin
        wr_t e;
        #1;
        if (wt_en) begin
            n_wr++;
            wt_run++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 128'(sb.size()), 128'd1);
            end else begin
                e = sb.pop_front();
                chk("wt_addr", 128'(wt_addr), 128'(e.addr));
                chk("wt_data", wt_data, e.data);
            end
            if (wt_addr[0] == 1'b0) begin
                chk("rd_addr1_pair", 128'(rd_addr1), 128'(CDF_BASE + (wt_addr - OUT_BASE)));
                chk("rd_addr2_pair", 128'(rd_addr2), 128'(CDF_BASE + (wt_addr - OUT_BASE) + 16'd1));
            end
        end else if (wt_run != 0) begin
            chk("wt_en_run_len", 128'(wt_run), 128'd2);
            wt_run = 0;
        end
        if (!reset) wt_run = 0;
        if (rd_done) begin
            n_rd_done++;
            chk("rd_done_last_pair", 128'(rd_addr1), 128'(CDF_BASE + 16'd62));
        end
        if (wt_done && !done_q) done_cyc = cyc;
        done_q = wt_done;
    end

    int start_cyc = 0;

    task automatic start_run(input logic [31:0] m);
        n_wr      = 0;
        n_rd_done = 0;
        cdf_min   = m;
        push_run(m);
        @(negedge clk);
        enable    = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk);
        #1;
        chk("start_rd_addrs", 128'({rd_addr1, rd_addr2}), 128'({CDF_BASE, CDF_BASE + 16'd1}));
        chk("start_done_clear", 128'(wt_done), 128'd0);
        repeat (9) @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !wt_done; i++) @(negedge clk);
        chk("done_seen", 128'(wt_done), 128'd1);
        chk("done_latency", 128'(done_cyc - start_cyc), 128'd416);
    endtask

    initial begin
        cdf_mem[0] = {4{32'd2401}};
        cdf_mem[1] = {4{32'd4801}};
        cdf_mem[2] = {32'd20000, 32'd16384, 32'd18, 32'd10};
        for (int w = 3; w < 64; w++)
            for (int l = 0; l < 4; l++) cdf_mem[w][32*l +: 32] = 32'($urandom_range(0, 20000));

        // Reset held with enable toggling: everything stays at zero.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            enable = ~enable;
            @(posedge clk);
            #1;
            chk("reset_wt_data", wt_data, 128'd0);
            chk("reset_ctrl", 128'({rd_addr1, rd_addr2, wt_addr, wt_en, rd_done, wt_done}), 128'd0);
        end
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_no_write", 128'(n_wr), 128'd0);
        chk("idle_no_done", 128'(wt_done), 128'd0);

        // Basic run with clamp lanes in word 2.
        start_run(32'd18);
        wait_done(1000);
        repeat (40) @(negedge clk);
        chk("run1_writes", 128'(n_wr), 128'd64);
        chk("run1_rd_done", 128'(n_rd_done), 128'd1);
        chk("run1_sb_empty", 128'(sb.size()), 128'd0);
        chk("run1_done_held", 128'(wt_done), 128'd1);
        chk("word64", out_mem[0], {4{32'd37}});
`ifdef HIST_EQ_ROUND_NEAREST_EN
        chk("word65", out_mem[1], {4{32'd75}});
`else
        chk("word65", out_mem[1], {4{32'd74}});
`endif
        chk("word66_clamps", out_mem[2], {32'd255, 32'd255, 32'd0, 32'd0});

        // Degenerate divisor: cdf_min equals the pixel count.
        start_run(32'd16384);
        wait_done(1000);
        repeat (5) @(negedge clk);
        chk("run2_writes", 128'(n_wr), 128'd64);
        chk("run2_sb_empty", 128'(sb.size()), 128'd0);
        chk("run2_word64", out_mem[0], 128'd0);
        chk("run2_word66", out_mem[2], {32'd255, 96'd0});

        // Abort in pair 10, then restart from pair 0.
        start_run(32'd18);
        for (int i = 0; i < 1000 && n_wr < 20; i++) @(negedge clk);
        chk("abort_reached_pair10", 128'(n_wr), 128'd20);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_wt_data", wt_data, 128'd0);
        chk("abort_ctrl", 128'({rd_addr1, rd_addr2, wt_addr, wt_en, rd_done, wt_done}), 128'd0);
        chk("abort_sb_left", 128'(sb.size()), 128'd44);
        sb.delete();
        repeat (5) @(negedge clk);
        chk("abort_no_writes", 128'(n_wr), 128'd20);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        start_run(32'd18);
        wait_done(1000);
        repeat (5) @(negedge clk);
        chk("run3_writes", 128'(n_wr), 128'd64);
        chk("run3_rd_done", 128'(n_rd_done), 128'd1);
        chk("run3_sb_empty", 128'(sb.size()), 128'd0);
        chk("run3_word64", out_mem[0], {4{32'd37}});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
